// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch FSM states, default widths and small helpers.
package cpu_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;

  // Canonical RISC-V no-op (addi x0, x0, 0).
  localparam logic [31:0] NOP_INSTR = 32'h00000013;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2,
    ERR  = 2'd3
  } fetch_state_t;

  // Instruction addresses must be word aligned.
  function automatic logic is_aligned(input logic [1:0] low_bits);
    return low_bits == 2'b00;
  endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Fetch-unit bus bundle: PC input, redirect, imem req/ack channel and decode valid/ready channel.
// The master side is the fetch unit; the slave side is its environment (PC register, imem, decode).
interface instr_fetch_unit_if
  import cpu_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);

  logic [ADDR_W-1:0] pc;
  logic              redirect;
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ack;
  logic [DATA_W-1:0] imem_rdata;
  logic              inst_valid;
  logic [DATA_W-1:0] inst;
  logic [ADDR_W-1:0] inst_pc;
  logic              inst_ready;
  logic              pc_advance;
  logic              fetch_err;

  modport master (
    input  pc, redirect, imem_ack, imem_rdata, inst_ready,
    output imem_req, imem_addr, inst_valid, inst, inst_pc, pc_advance, fetch_err
  );

  modport slave (
    output pc, redirect, imem_ack, imem_rdata, inst_ready,
    input  imem_req, imem_addr, inst_valid, inst, inst_pc, pc_advance, fetch_err
  );

endinterface

// File: rtl/fetch_watchdog.sv
// Counts consecutive request cycles without an acknowledge and flags a timeout
// in the cycle that would make the wait reach TIMEOUT cycles. TIMEOUT = 0 disables it.
module fetch_watchdog #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic clr,
  input  logic en,
  input  logic clear,
  output logic timeout
);

  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] LIMIT = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Next count: an acknowledge restarts the wait, otherwise each unanswered cycle adds one.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (en) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  // Count register, cleared asynchronously with the rest of the fetch unit.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign timeout = (TIMEOUT != 0) && en && (count_q == LIMIT);

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: issues one imem read per PC, buffers the returned word for decode
// behind a valid/ready handshake, pulses pc_advance when a word is delivered, and latches
// a sticky error on a misaligned PC or an imem acknowledge timeout.
module instr_fetch_unit
  import cpu_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               clr,
  instr_fetch_unit_if.master bus
);

  fetch_state_t      state_q, state_d;
  logic              drop_q, drop_d;
  logic              imem_req_q, imem_req_d;
  logic [ADDR_W-1:0] imem_addr_q, imem_addr_d;
  logic              inst_valid_q, inst_valid_d;
  logic [DATA_W-1:0] inst_q, inst_d;
  logic [ADDR_W-1:0] inst_pc_q, inst_pc_d;
  logic              pc_advance_q, pc_advance_d;
  logic              fetch_err_q, fetch_err_d;

  logic              discard;
  logic              wd_en;
  logic              wd_clear;
  logic              timeout;
  logic [ADDR_W-1:0] capture_addr;
  logic              capture_ok;

  // A redirect seen earlier in this request, or arriving with the ack, poisons the returned word.
  assign discard  = drop_q || bus.redirect;
  assign wd_en    = (state_q == REQ) && !bus.imem_ack;
  assign wd_clear = (state_q == REQ) && bus.imem_ack;

  // The PC register only loads on the edge that closes the pc_advance cycle, so if decode takes
  // the word in that very cycle the pc input still shows the old address; use the advanced
  // address directly. A redirect always supplies its target on pc, so it bypasses this.
  assign capture_addr = (state_q == HOLD && !bus.redirect && pc_advance_q)
                        ? inst_pc_q + ADDR_W'(4)
                        : bus.pc;
  assign capture_ok   = is_aligned(capture_addr[1:0]);

  fetch_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk     (clk),
    .clr     (clr),
    .en      (wd_en),
    .clear   (wd_clear),
    .timeout (timeout)
  );

  // State register.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: every new address capture goes to REQ, or to ERR when misaligned.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        state_d = capture_ok ? REQ : ERR;
      end
      REQ: begin
        if (bus.imem_ack) begin
          if (discard) begin
            state_d = capture_ok ? REQ : ERR;
          end else begin
            state_d = HOLD;
          end
        end else if (timeout) begin
          state_d = ERR;
        end
      end
      HOLD: begin
        if (bus.redirect || bus.inst_ready) begin
          state_d = capture_ok ? REQ : ERR;
        end
      end
      ERR: begin
        state_d = ERR;
      end
      default: begin
        state_d = ERR;
      end
    endcase
  end

  // Output and buffer next values; everything here is registered before it leaves the block.
  always_comb begin
    imem_addr_d  = imem_addr_q;
    inst_d       = inst_q;
    inst_pc_d    = inst_pc_q;
    inst_valid_d = inst_valid_q;
    drop_d       = drop_q;
    pc_advance_d = 1'b0;
    imem_req_d   = (state_d == REQ);
    fetch_err_d  = (state_d == ERR);
    case (state_q)
      IDLE: begin
        if (state_d == REQ) begin
          imem_addr_d = capture_addr;
        end
      end
      REQ: begin
        if (bus.imem_ack) begin
          drop_d = 1'b0;
          if (discard) begin
            if (state_d == REQ) begin
              imem_addr_d = capture_addr;
            end
          end else begin
            inst_d       = bus.imem_rdata;
            inst_pc_d    = imem_addr_q;
            inst_valid_d = 1'b1;
            pc_advance_d = 1'b1;
          end
        end else if (bus.redirect) begin
          drop_d = 1'b1;
        end
      end
      HOLD: begin
        if (state_d == REQ) begin
          inst_valid_d = 1'b0;
          imem_addr_d  = capture_addr;
        end
      end
      default: begin
      end
    endcase
    if (state_d == ERR) begin
      inst_valid_d = 1'b0;
      pc_advance_d = 1'b0;
      drop_d       = 1'b0;
    end
  end

  // Output and buffer registers; clearing them drops imem_req immediately, even mid-request.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      imem_req_q   <= 1'b0;
      imem_addr_q  <= '0;
      inst_valid_q <= 1'b0;
      inst_q       <= '0;
      inst_pc_q    <= '0;
      pc_advance_q <= 1'b0;
      fetch_err_q  <= 1'b0;
      drop_q       <= 1'b0;
    end else begin
      imem_req_q   <= imem_req_d;
      imem_addr_q  <= imem_addr_d;
      inst_valid_q <= inst_valid_d;
      inst_q       <= inst_d;
      inst_pc_q    <= inst_pc_d;
      pc_advance_q <= pc_advance_d;
      fetch_err_q  <= fetch_err_d;
      drop_q       <= drop_d;
    end
  end

  assign bus.imem_req   = imem_req_q;
  assign bus.imem_addr  = imem_addr_q;
  assign bus.inst_valid = inst_valid_q;
  assign bus.inst       = inst_q;
  assign bus.inst_pc    = inst_pc_q;
  assign bus.pc_advance = pc_advance_q;
  assign bus.fetch_err  = fetch_err_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Testbench for instr_fetch_unit: the bench plays PC register, instruction memory and decode.
// Expected instructions are queued when memory answers a fetch and checked when decode takes them.
module tb_instr_fetch_unit;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] word;
  } expT;

  logic clk = 1'b0;
  logic clr;
  logic clr2;

  int vectors     = 0;
  int miscompares = 0;

  instr_fetch_unit_if bus ();
  instr_fetch_unit_if bus2 ();

  instr_fetch_unit #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(255)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  instr_fetch_unit #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut4 (
    .clk (clk),
    .clr (clr2),
    .bus (bus2)
  );

  // Free-running clock, period 10.
  always #5 clk = ~clk;

  // Stimulus-side state: PC register model and memory latency model.
  logic [31:0] pcReg;
  bit          prevAdvDrv;
  bit          prevRedirDrv;
  int          waitCnt;
  int          ackDelay;

  // Scoreboard-side state.
  expT         sbQ[$];
  expT         e;
  bit          monEn = 1'b0;
  bit          dropPending;
  bit          expAdv;
  bit          nextAdv;
  logic [31:0] expectFetch;
  bit          prevReq;
  bit          prevAck;
  logic [31:0] prevAddr;
  int          stallCnt;
  int          delivered;

  // Directed-phase locals.
  int          reqCycles;
  bit          sawErr;

  // Instruction memory contents: a fixed scramble of the address.
  function automatic logic [31:0] memWord(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h00500093;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One cycle of environment behaviour, driven just after the falling edge.
  task automatic applyStimulus();
    if (prevAdvDrv && !prevRedirDrv) pcReg = pcReg + 32'd4;
    bus.redirect = 1'b0;
    if ($urandom_range(0, 99) < 8) begin
      bus.redirect = 1'b1;
      pcReg = $urandom & 32'h0000_FFFC;
    end
    bus.pc = pcReg;
    prevAdvDrv   = bus.pc_advance;
    prevRedirDrv = bus.redirect;
    bus.imem_ack   = 1'b0;
    bus.imem_rdata = $urandom;
    if (bus.imem_req) begin
      if (waitCnt >= ackDelay) begin
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = memWord(bus.imem_addr);
        waitCnt  = 0;
        ackDelay = $urandom_range(0, 4);
      end else begin
        waitCnt++;
      end
    end
    bus.inst_ready = ($urandom_range(0, 99) < 60);
  endtask

  // Monitor: checks decode handshakes against the scoreboard and tracks which fetches survive.
  always @(negedge clk) begin
    #2;
    if (monEn) begin
      nextAdv = 1'b0;
      if (expAdv || bus.pc_advance) checkOutput("pc_advance", 32'(bus.pc_advance), 32'(expAdv));
      if (expAdv) checkOutput("valid_after_ack", 32'(bus.inst_valid), 32'd1);
      checkOutput("req_during_hold", 32'(bus.imem_req & bus.inst_valid), 32'd0);
      if (prevReq && !prevAck && bus.imem_req) checkOutput("addr_stable", bus.imem_addr, prevAddr);

      if (bus.inst_valid && bus.inst_ready && !bus.redirect) begin
        checkOutput("sb_occupancy", 32'(sbQ.size()), 32'd1);
        if (sbQ.size() > 0) begin
          e = sbQ.pop_front();
          checkOutput("inst", bus.inst, e.word);
          checkOutput("inst_pc", bus.inst_pc, e.pc);
        end
        delivered++;
        stallCnt = 0;
      end else begin
        stallCnt++;
      end

      if (bus.imem_req && bus.imem_ack) begin
        if (!(dropPending || bus.redirect)) begin
          checkOutput("fetch_addr", bus.imem_addr, expectFetch);
          sbQ.push_back('{pc: expectFetch, word: memWord(expectFetch)});
          expectFetch = expectFetch + 32'd4;
          nextAdv = 1'b1;
        end
        dropPending = 1'b0;
      end

      if (bus.redirect) begin
        sbQ.delete();
        if (bus.imem_req && !bus.imem_ack) dropPending = 1'b1;
        expectFetch = bus.pc;
      end

      if (stallCnt == 200) checkOutput("progress_stall", 32'(stallCnt), 32'd0);

      expAdv   = nextAdv;
      prevReq  = bus.imem_req;
      prevAck  = bus.imem_ack;
      prevAddr = bus.imem_addr;
    end
  end

  // Hard stop in case something upstream never returns.
  initial begin
    #2000000;
    $display("[TB] FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "[TB] time limit");
  end

  // Main sequence: reset behaviour, randomized traffic, then error cases.
  initial begin
    clr = 1'b1;
    clr2 = 1'b1;
    bus.pc = '0; bus.redirect = 1'b0; bus.imem_ack = 1'b0; bus.imem_rdata = '0; bus.inst_ready = 1'b0;
    bus2.pc = '0; bus2.redirect = 1'b0; bus2.imem_ack = 1'b0; bus2.imem_rdata = '0; bus2.inst_ready = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst_imem_req", 32'(bus.imem_req), 32'd0);
    checkOutput("rst_imem_addr", bus.imem_addr, 32'd0);
    checkOutput("rst_inst_valid", 32'(bus.inst_valid), 32'd0);
    checkOutput("rst_inst", bus.inst, 32'd0);
    checkOutput("rst_inst_pc", bus.inst_pc, 32'd0);
    checkOutput("rst_pc_advance", 32'(bus.pc_advance), 32'd0);
    checkOutput("rst_fetch_err", 32'(bus.fetch_err), 32'd0);

    clr = 1'b0;
    @(negedge clk);
    checkOutput("req_after_release", 32'(bus.imem_req), 32'd1);
    checkOutput("addr_after_release", bus.imem_addr, 32'd0);
    @(negedge clk);
    #1 clr = 1'b1;
    #1;
    checkOutput("req_drop_async", 32'(bus.imem_req), 32'd0);
    checkOutput("valid_drop_async", 32'(bus.inst_valid), 32'd0);
    checkOutput("err_drop_async", 32'(bus.fetch_err), 32'd0);
    @(negedge clk);
    @(negedge clk);
    clr = 1'b0;
    @(negedge clk);
    checkOutput("req_after_rerelease", 32'(bus.imem_req), 32'd1);
    checkOutput("addr_after_rerelease", bus.imem_addr, 32'd0);

    pcReg = 32'd0; prevAdvDrv = 1'b0; prevRedirDrv = 1'b0;
    waitCnt = 0; ackDelay = $urandom_range(0, 4);
    sbQ.delete(); expectFetch = 32'd0; dropPending = 1'b0; expAdv = 1'b0;
    prevReq = 1'b0; prevAck = 1'b0; prevAddr = '0; stallCnt = 0; delivered = 0;
    monEn = 1'b1;
    repeat (3000) begin
      applyStimulus();
      @(negedge clk);
    end
    monEn = 1'b0;
    clr = 1'b1;
    checkOutput("random_no_err", 32'(bus.fetch_err), 32'd0);
    checkOutput("random_deliveries", 32'(delivered > 100), 32'd1);

    bus.pc = 32'h0000_0042; bus.redirect = 1'b0; bus.imem_ack = 1'b0; bus.inst_ready = 1'b0;
    repeat (2) @(negedge clk);
    clr = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput("misalign_err", 32'(bus.fetch_err), 32'd1);
      checkOutput("misalign_no_req", 32'(bus.imem_req), 32'd0);
    end
    bus.redirect = 1'b1;
    bus.pc = 32'h0000_0080;
    @(negedge clk);
    bus.redirect = 1'b0;
    @(negedge clk);
    checkOutput("misalign_err_held", 32'(bus.fetch_err), 32'd1);
    checkOutput("misalign_valid", 32'(bus.inst_valid), 32'd0);

    clr2 = 1'b0;
    reqCycles = 0;
    sawErr = 1'b0;
    for (int i = 0; i < 20 && !sawErr; i++) begin
      @(negedge clk);
      if (bus2.fetch_err) sawErr = 1'b1;
      else if (bus2.imem_req) reqCycles++;
    end
    checkOutput("timeout_req_cycles", 32'(reqCycles), 32'd4);
    checkOutput("timeout_err", 32'(sawErr), 32'd1);
    bus2.redirect = 1'b1;
    bus2.pc = 32'h0000_0100;
    @(negedge clk);
    bus2.redirect = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("timeout_err_sticky", 32'(bus2.fetch_err), 32'd1);
    checkOutput("timeout_no_req", 32'(bus2.imem_req), 32'd0);
    #1 clr2 = 1'b1;
    #1;
    checkOutput("timeout_err_cleared", 32'(bus2.fetch_err), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
